// File: rtl/walk_sensor_conditioner.sv
// Walk button / car sensor synchronizer, debouncer and walk request latch.
// Optional post-acknowledge press lockout: define WALK_LOCKOUT_EN.
module walk_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned LOCKOUT_CYCLES  = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic walk_button,
  input  logic sensor_raw,
  input  logic walk_ack,
  output logic walk_pending,
  output logic walk_press_pulse,
  output logic sensor_clean
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    B_IDLE,
    B_PRESS,
    B_HELD,
    B_REL
  } bstate_t;

  logic btn_s1_q, btn_s_q;
  logic sen_s1_q, sen_s_q;

  bstate_t          bstate_q, bstate_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             pulse_q, pulse_d;
  logic             pending_q, pending_d;
  logic             clean_q, clean_d;
  logic             press_ok;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

`ifdef WALK_LOCKOUT_EN
  localparam int unsigned LK_W =
    (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_LOAD =
    LK_W'(LOCKOUT_CYCLES);

  logic [LK_W-1:0] lock_q, lock_d;

  // Lockout begins the cycle after ack, so a press
  // accepted alongside the ack still goes through.
  always_comb begin
    lock_d = lock_q;
    if (walk_ack && (pending_q || pulse_q)) begin
      lock_d = LK_LOAD;
    end else if (lock_q != '0) begin
      lock_d = lock_q - 1'b1;
    end
  end

  assign press_ok = (lock_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_lockout;
  assign unused_lockout = ^LOCKOUT_CYCLES;
  assign press_ok       = 1'b1;
`endif

  // Entering B_PRESS counts the first stable sample.
  always_comb begin
    bstate_d = bstate_q;
    bcnt_d   = bcnt_q;
    pulse_d  = 1'b0;
    unique case (bstate_q)
      B_IDLE: begin
        bcnt_d = '0;
        if (btn_s_q) begin
          bstate_d = B_PRESS;
          bcnt_d   = CNT_W'(1);
        end
      end
      B_PRESS: begin
        if (!btn_s_q) begin
          bstate_d = B_IDLE;
          bcnt_d   = '0;
        end else if (bcnt_q == TERM) begin
          bstate_d = B_HELD;
          bcnt_d   = '0;
          pulse_d  = press_ok;
        end else begin
          bcnt_d = sat_inc(bcnt_q);
        end
      end
      B_HELD: begin
        bcnt_d = '0;
        if (!btn_s_q) begin
          bstate_d = B_REL;
        end
      end
      B_REL: begin
        if (btn_s_q) begin
          bstate_d = B_HELD;
          bcnt_d   = '0;
        end else if (bcnt_q == TERM) begin
          bstate_d = B_IDLE;
          bcnt_d   = '0;
        end else begin
          bcnt_d = sat_inc(bcnt_q);
        end
      end
      default: begin
        bstate_d = B_IDLE;
        bcnt_d   = '0;
      end
    endcase
  end

  // Set has priority so a press never gets lost to an ack.
  always_comb begin
    pending_d = pending_q;
    if (pulse_q) begin
      pending_d = 1'b1;
    end else if (walk_ack) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    clean_d = clean_q;
    scnt_d  = '0;
    if (sen_s_q != clean_q) begin
      if (scnt_q == TERM) begin
        clean_d = sen_s_q;
      end else begin
        scnt_d = sat_inc(scnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q  <= 1'b0;
      btn_s_q   <= 1'b0;
      sen_s1_q  <= 1'b0;
      sen_s_q   <= 1'b0;
      bstate_q  <= B_IDLE;
      bcnt_q    <= '0;
      scnt_q    <= '0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
      clean_q   <= 1'b0;
    end else begin
      btn_s1_q  <= walk_button;
      btn_s_q   <= btn_s1_q;
      sen_s1_q  <= sensor_raw;
      sen_s_q   <= sen_s1_q;
      bstate_q  <= bstate_d;
      bcnt_q    <= bcnt_d;
      scnt_q    <= scnt_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      clean_q   <= clean_d;
    end
  end

  assign walk_pending     = pending_q;
  assign walk_press_pulse = pulse_q;
  assign sensor_clean     = clean_q;

endmodule

// File: tb/tb_walk_sensor_conditioner.sv
// Self-checking bench for walk_sensor_conditioner.
// Vector table, corner sequences, then random vs model.
module tb_walk_sensor_conditioner;

  localparam int D  = 4;
  localparam int LK = 20;
`ifdef WALK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic walk_button = 1'b0;
  logic sensor_raw = 1'b0;
  logic walk_ack = 1'b0;
  logic walk_pending, walk_press_pulse, sensor_clean;

  int asserts = 0;
  int fails = 0;

  walk_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4),
    .LOCKOUT_CYCLES(LK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .walk_button(walk_button),
    .sensor_raw(sensor_raw),
    .walk_ack(walk_ack),
    .walk_pending(walk_pending),
    .walk_press_pulse(walk_press_pulse),
    .sensor_clean(sensor_clean)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: sampled history and run lengths.
  logic m_b1, m_b2, m_s1, m_s2;
  logic m_blvl, m_sclean, m_pulse, m_pend;
  int   m_brun, m_srun, m_lock;

  task automatic model_edge(input logic r, input logic b,
                            input logic s, input logic a);
    logic p_new;
    if (r) begin
      {m_b1, m_b2, m_s1, m_s2} = '0;
      m_blvl = 0; m_sclean = 0;
      m_pulse = 0; m_pend = 0;
      m_brun = 0; m_srun = 0; m_lock = 0;
      return;
    end
    p_new = 1'b0;
    if (!m_blvl) begin
      m_brun = m_b2 ? m_brun + 1 : 0;
      if (m_brun == D) begin
        m_blvl = 1; m_brun = 0;
        p_new = (m_lock == 0);
      end
    end else begin
      m_brun = !m_b2 ? m_brun + 1 : 0;
      if (m_brun == D + 1) begin
        m_blvl = 0; m_brun = 0;
      end
    end
    if (LOCK_EN) begin
      if (a && (m_pend || m_pulse)) m_lock = LK;
      else if (m_lock > 0) m_lock = m_lock - 1;
    end
    m_pend = m_pulse | (m_pend & ~a);
    m_pulse = p_new;
    m_srun = (m_s2 != m_sclean) ? m_srun + 1 : 0;
    if (m_srun == D) begin
      m_sclean = m_s2; m_srun = 0;
    end
    m_b2 = m_b1; m_b1 = b;
    m_s2 = m_s1; m_s1 = s;
  endtask

  task automatic step(input logic r, input logic b,
                      input logic s, input logic a);
    rst = r; walk_button = b;
    sensor_raw = s; walk_ack = a;
    @(posedge clk);
    model_edge(r, b, s, a);
    #1;
  endtask

  task automatic chk(input string name, input logic act,
                     input logic exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b",
               name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act,
                         input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic r, b, s, a;
    logic e_pend, e_pulse, e_sen;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic r, logic b, logic s,
                              logic a, logic ep, logic eu,
                              logic es);
    vec_t v;
    v.r = r; v.b = b; v.s = s; v.a = a;
    v.e_pend = ep; v.e_pulse = eu; v.e_sen = es;
    return v;
  endfunction

  initial begin
    int pc, pe, hold;
    logic rb, rs, seen;
    model_edge(1'b1, 1'b0, 1'b0, 1'b0);

    // 3 reset cycles, then clean press + sensor rise, ack.
    for (int i = 0; i < 3; i++)
      vt[i] = mk(1, 1, 1, 0, 0, 0, 0);
    for (int i = 3; i < 8; i++)
      vt[i] = mk(0, 1, 1, 0, 0, 0, 0);
    vt[8]  = mk(0, 1, 1, 0, 0, 1, 1);
    vt[9]  = mk(0, 1, 1, 0, 1, 0, 1);
    vt[10] = mk(0, 1, 1, 0, 1, 0, 1);
    vt[11] = mk(0, 1, 1, 1, 0, 0, 1);
    vt[12] = mk(0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].b, vt[i].s, vt[i].a);
      chk($sformatf("vec%0d_pend", i),
          walk_pending, vt[i].e_pend);
      chk($sformatf("vec%0d_pulse", i),
          walk_press_pulse, vt[i].e_pulse);
      chk($sformatf("vec%0d_sen", i),
          sensor_clean, vt[i].e_sen);
    end

    // Press bounce then stable hold.
    step(1, 0, 0, 0);
    pc = 0; pe = 0;
    for (int k = 1; k <= 14; k++) begin
      step(0, (k <= 4) ? k[0] : 1'b1, 0, 0);
      if (walk_press_pulse) begin
        pc++; pe = k;
      end
    end
    chk_int("bounce_pulse_count", pc, 1);
    chk_int("bounce_pulse_edge", pe, 10);
    chk("bounce_pending", walk_pending, 1'b1);

    // Release with bounce.
    pc = 0;
    for (int k = 1; k <= 13; k++) begin
      step(0, (k == 2), 0, 0);
      if (walk_press_pulse) pc++;
    end
    chk_int("release_no_pulse", pc, 0);
    chk("release_pending", walk_pending, 1'b1);

    // Ack clears; then press and ack coincide.
    step(0, 0, 0, 1);
    chk("ack_clear", walk_pending, 1'b0);
    for (int k = 0; k < 25; k++) step(0, 0, 0, 0);
    chk("idle_pending", walk_pending, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 0, (k == 7));
      if (k == 6) chk("coinc_pulse", walk_press_pulse, 1'b1);
    end
    chk("coinc_pend", walk_pending, 1'b1);
    step(0, 1, 0, 0);
    chk("coinc_pend_hold", walk_pending, 1'b1);

    // Sensor glitch, rise, fall.
    seen = 0; pc = 0;
    for (int k = 1; k <= 11; k++) begin
      step(0, 1, (k <= 3), 0);
      seen |= sensor_clean;
      if (walk_press_pulse) pc++;
    end
    chk("sen_glitch", seen, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 1, 0);
      chk($sformatf("sen_rise%0d", k), sensor_clean, k >= 6);
      if (walk_press_pulse) pc++;
    end
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 0, 0);
      chk($sformatf("sen_fall%0d", k), sensor_clean, k < 6);
      if (walk_press_pulse) pc++;
    end
    chk_int("held_no_retrigger", pc, 0);

    // Reset mid-debounce with pending set.
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_mid_pend", walk_pending, 1'b0);
    chk("rst_mid_pulse", walk_press_pulse, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 0, 0);
      chk($sformatf("rst_press%0d", k),
          walk_press_pulse, k == 6);
    end
    step(0, 1, 0, 0);
    chk("rst_press_pend", walk_pending, 1'b1);

    // Lockout window after ack.
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("lock_ack_clear", walk_pending, 1'b0);
    pc = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0);
      if (walk_press_pulse) pc++;
    end
    chk_int("lock_early_pulses", pc, LOCK_EN ? 0 : 1);
    chk("lock_early_pend", walk_pending, !LOCK_EN);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 0);
    pc = 0;
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 0, 0);
      if (walk_press_pulse) pc++;
    end
    chk_int("lock_late_pulses", pc, 1);
    chk("lock_late_pend", walk_pending, 1'b1);

    // Random traffic against the model.
    rb = 0; rs = 0; hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        hold = $urandom_range(9, 1);
        if ($urandom_range(1) == 1) rb = ~rb;
        if ($urandom_range(1) == 1) rs = ~rs;
      end
      hold--;
      step($urandom_range(799) == 0, rb, rs,
           $urandom_range(15) == 0);
      chk("rnd_pend", walk_pending, m_pend);
      chk("rnd_pulse", walk_press_pulse, m_pulse);
      chk("rnd_sen", sensor_clean, m_sclean);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/walk_sensor_conditioner.md
Name: walk_sensor_conditioner

Overview:
- Input-conditioning stage directly upstream of the traffic light controller.
- Synchronizes and debounces the raw pedestrian walk button and the side-street car sensor.
- Holds the walk request as a pending flag until the controller acknowledges it on entering the pedestrian phase.
- Replaces the edge-triggered walk latch with a single-clock, fully synchronous request/acknowledge handshake.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a level change (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, width of the debounce counters; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- LOCKOUT_CYCLES, 2000000, post-acknowledge press lockout length; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- walk_button  in  1  raw asynchronous pushbutton, high = pressed
- sensor_raw  in  1  raw asynchronous car sensor, high = car present
- walk_ack  in  1  one-cycle pulse from the controller when it enters the pedestrian phase
- walk_pending  out  1  latched walk request, held until acknowledged
- walk_press_pulse  out  1  one-cycle pulse per accepted press
- sensor_clean  out  1  debounced sensor level

Behaviour:
- Reset (sampled on a clk edge with rst=1):
  - walk_pending=0, walk_press_pulse=0, sensor_clean=0.
  - All synchronizer flops cleared, both counters cleared, button FSM to B_IDLE.
  - Reset mid-debounce discards partial counts.
  - Reset while pending clears the request.
- Synchronizers: each raw input passes through 2 flops (btn_s, sen_s). All logic below uses only btn_s and sen_s.
- Button FSM, counter bcnt:
  - B_IDLE: bcnt=0. btn_s=1 -> B_PRESS.
  - B_PRESS: btn_s=0 -> B_IDLE (bounce rejected, bcnt=0). Otherwise bcnt increments. When bcnt==DEBOUNCE_CYCLES-1 and btn_s=1 -> B_HELD; walk_press_pulse=1 for exactly that next cycle.
  - B_HELD: btn_s=0 -> B_REL with bcnt=0. A held button never re-triggers.
  - B_REL: btn_s=1 -> B_HELD (release bounce). Otherwise bcnt increments. When bcnt==DEBOUNCE_CYCLES-1 -> B_IDLE.
- Latency: walk_press_pulse rises DEBOUNCE_CYCLES+2 clk edges after walk_button is first sampled high, given a clean press.
- walk_pending:
  - Set on the cycle after walk_press_pulse.
  - Cleared on the cycle after walk_ack.
  - Press and ack in the same cycle: set wins, so walk_pending=1 and no request is lost.
  - Repeated presses while pending: pending stays 1, nothing is queued.
- Sensor debounce, counter scnt:
  - sen_s != sensor_clean: scnt increments. On reaching DEBOUNCE_CYCLES-1, sensor_clean takes sen_s and scnt=0.
  - sen_s == sensor_clean: scnt=0.
  - Symmetric for rise and fall. Latency DEBOUNCE_CYCLES+2 edges.
- Counters saturate, never wrap: the terminal compare fires before CNT_W overflow.
- walk_ack with no pending request has no effect.

Optional Feature:
- Macro: WALK_LOCKOUT_EN.
- Enabled:
  - walk_ack loads a lockout counter with LOCKOUT_CYCLES.
  - While the counter is nonzero it decrements each cycle, and accepted presses (B_PRESS->B_HELD) produce neither walk_press_pulse nor a pending set.
  - The FSM still advances normally.
  - Press and ack in the same cycle: the press is accepted, because lockout starts the next cycle.
- Disabled: no lockout counter; LOCKOUT_CYCLES is ignored; every accepted press pulses and sets pending.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: assert rst 3 cycles -> all outputs 0. Hold walk_button=1 -> walk_press_pulse high exactly 1 cycle, 6 edges after first sample; walk_pending=1 the next cycle and stays 1.
- Bounce: walk_button toggles 1,0,1,0 each cycle, then holds 1 -> no pulse during toggling; exactly one pulse after 4 stable cycles. Release with 2-cycle bounce -> no second pulse.
- Handshake: pending=1, pulse walk_ack -> walk_pending=0 next cycle. Force press pulse and ack in the same cycle -> walk_pending=1.
- Sensor: sensor_raw glitches high 3 cycles -> sensor_clean stays 0. Held high 10 cycles -> sensor_clean=1 at edge 6. Symmetric fall.
- Reset mid-operation: assert rst with bcnt=2 and pending=1 -> pending=0, FSM idle, and no pulse when the button is still held after reset until a full 4-cycle debounce.
- WALK_LOCKOUT_EN, LOCKOUT_CYCLES=20: ack, then a clean press within 10 cycles -> no pulse, pending stays 0. Press after 25 cycles -> pulse and pending=1. Macro undefined -> the first press also pulses.
